// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// 7-segment encoding, leading-zero blanking and overflow dash display.
module bcd_display_seq #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 4,
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     shreg, shreg_nxt;
    logic [4*DIGITS-1:0]  scratch, adj, scratch_nxt;
    logic                 ovf, ovf_nxt, carry;
    logic [CNT_W-1:0]     cnt;
    logic                 last_shift;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    // Digits are walked from the top so upper_zero tracks "all digits i..DIGITS-1 are zero".
    function automatic logic [7*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] v, input logic o);
        logic [7*DIGITS-1:0] s;
        logic                upper_zero;
        s          = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (v[4*i +: 4] == 4'd0);
            if (o)
                s[7*i +: 7] = 7'h40;
            else if (BLANK_LZ && (i > 0) && upper_zero)
                s[7*i +: 7] = 7'h00;
            else
                s[7*i +: 7] = seg_code(v[4*i +: 4]);
        end
        return ACTIVE_LOW ? ~s : s;
    endfunction

    // Add-3 on every nibble, then shift the whole {ovf, scratch, shreg} chain left by one.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        {carry, scratch_nxt, shreg_nxt} = {adj, shreg, 1'b0};
        ovf_nxt    = ovf | carry;
        last_shift = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Working registers carry no reset; they are fully reloaded on every accepted start.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    shreg   <= bin;
                    scratch <= '0;
                    ovf     <= 1'b0;
                    cnt     <= CNT_W'(WIDTH);
                end
            end
            SHIFT: begin
                shreg   <= shreg_nxt;
                scratch <= scratch_nxt;
                ovf     <= ovf_nxt;
                cnt     <= cnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Displayed result only moves on the edge entering DONE, so the HEX digits never flicker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd      <= '0;
            overflow <= 1'b0;
            seg      <= encode({4*DIGITS{1'b0}}, 1'b0);
        end else if (state == SHIFT && last_shift) begin
            bcd      <= scratch_nxt;
            overflow <= ovf_nxt;
            seg      <= encode(scratch_nxt, ovf_nxt);
        end
    end
endmodule

// File: tb/tb_bcd_display_seq.sv
// Directed bench for bcd_display_seq: default config, a 2-digit overflow config
// and a 16-bit/5-digit unblanked config, all active-low.
module tb_bcd_display_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start0, busy0, done0, ovf0;
    logic [7:0]  bin0;
    logic [15:0] bcd0;
    logic [27:0] seg0;

    logic        start1, busy1, done1, ovf1;
    logic [7:0]  bin1;
    logic [7:0]  bcd1;
    logic [13:0] seg1;

    logic        start2, busy2, done2, ovf2;
    logic [15:0] bin2;
    logic [19:0] bcd2;
    logic [34:0] seg2;

    int checks = 0;
    int failures = 0;

    bcd_display_seq u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0), .busy(busy0),
        .done(done0), .overflow(ovf0), .bcd(bcd0), .seg(seg0)
    );

    bcd_display_seq #(.WIDTH(8), .DIGITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1), .busy(busy1),
        .done(done1), .overflow(ovf1), .bcd(bcd1), .seg(seg1)
    );

    bcd_display_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2), .busy(busy2),
        .done(done2), .overflow(ovf2), .bcd(bcd2), .seg(seg2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stimulus only: start one conversion and wait (bounded) for done.
    task automatic run0(input logic [7:0] v, output bit got);
        step();
        start0 = 1'b1; bin0 = v;
        step();
        start0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (done0) got = 1'b1;
        end
    endtask

    task automatic run1(input logic [7:0] v, output bit got);
        step();
        start1 = 1'b1; bin1 = v;
        step();
        start1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (done1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0;
        step();
        rst_n = 1'b1;
        checks++; if (seg0 !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL reset_seg0 got=%h exp=%h", seg0, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        checks++; if (bcd0 !== 16'h0000) begin failures++; $display("FAIL reset_bcd0 got=%h exp=0000", bcd0); end
        checks++; if ({busy0, done0, ovf0} !== 3'b000) begin failures++; $display("FAIL reset_ctrl0 got=%b exp=000", {busy0, done0, ovf0}); end
        checks++; if (seg1 !== {7'h7F, 7'h40}) begin failures++; $display("FAIL reset_seg1 got=%h exp=%h", seg1, {7'h7F, 7'h40}); end
        checks++; if (seg2 !== {5{7'h40}}) begin failures++; $display("FAIL reset_seg2 got=%h exp=%h", seg2, {5{7'h40}}); end
    endtask

    task automatic test_convert();
        start0 = 1'b1; bin0 = 8'd255;
        step();
        start0 = 1'b0; bin0 = 8'h11;
        checks++; if ({busy0, done0} !== 2'b10) begin failures++; $display("FAIL conv_busy got=%b exp=10", {busy0, done0}); end
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin start0 = 1'b1; bin0 = 8'd1; end
            else start0 = 1'b0;
            step();
            checks++; if (done0 !== (k == 8)) begin failures++; $display("FAIL conv_done_k%0d got=%b exp=%b", k, done0, (k == 8)); end
            if (k == 4) begin
                checks++; if (bcd0 !== 16'h0000) begin failures++; $display("FAIL conv_hold got=%h exp=0000", bcd0); end
            end
        end
        checks++; if (bcd0 !== 16'h0255) begin failures++; $display("FAIL conv_bcd got=%h exp=0255", bcd0); end
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL conv_ovf got=%b exp=0", ovf0); end
        checks++; if (seg0 !== {7'h7F, 7'h24, 7'h12, 7'h12}) begin failures++; $display("FAIL conv_seg got=%h exp=%h", seg0, {7'h7F, 7'h24, 7'h12, 7'h12}); end
        step();
        checks++; if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL conv_idle got=%b exp=00", {busy0, done0}); end
    endtask

    task automatic test_blanking();
        bit got;
        run0(8'd0, got);
        checks++; if (!got) begin failures++; $display("FAIL blank0_timeout got=0 exp=1"); end
        checks++; if (seg0 !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL blank0_seg got=%h exp=%h", seg0, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        run0(8'd105, got);
        checks++; if (!got) begin failures++; $display("FAIL blank105_timeout got=0 exp=1"); end
        checks++; if (bcd0 !== 16'h0105) begin failures++; $display("FAIL blank105_bcd got=%h exp=0105", bcd0); end
        checks++; if (seg0 !== {7'h7F, 7'h79, 7'h40, 7'h12}) begin failures++; $display("FAIL blank105_seg got=%h exp=%h", seg0, {7'h7F, 7'h79, 7'h40, 7'h12}); end
    endtask

    task automatic test_overflow();
        bit got;
        run1(8'd200, got);
        checks++; if (!got) begin failures++; $display("FAIL ovf200_timeout got=0 exp=1"); end
        checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL ovf200_flag got=%b exp=1", ovf1); end
        checks++; if (bcd1 !== 8'h00) begin failures++; $display("FAIL ovf200_bcd got=%h exp=00", bcd1); end
        checks++; if (seg1 !== {7'h3F, 7'h3F}) begin failures++; $display("FAIL ovf200_seg got=%h exp=%h", seg1, {7'h3F, 7'h3F}); end
        run1(8'd42, got);
        checks++; if ({ovf1, bcd1} !== {1'b0, 8'h42}) begin failures++; $display("FAIL ovf42_res got=%h exp=%h", {ovf1, bcd1}, {1'b0, 8'h42}); end
        checks++; if (seg1 !== {7'h19, 7'h24}) begin failures++; $display("FAIL ovf42_seg got=%h exp=%h", seg1, {7'h19, 7'h24}); end
        run1(8'd99, got);
        checks++; if ({ovf1, bcd1} !== {1'b0, 8'h99}) begin failures++; $display("FAIL ovf99_res got=%h exp=%h", {ovf1, bcd1}, {1'b0, 8'h99}); end
        run1(8'd100, got);
        checks++; if ({ovf1, bcd1} !== {1'b1, 8'h00}) begin failures++; $display("FAIL ovf100_res got=%h exp=%h", {ovf1, bcd1}, {1'b1, 8'h00}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [4];
        logic [15:0] exp_bcd [4];
        vals    = '{8'd17, 8'd99, 8'd128, 8'd5};
        exp_bcd = '{16'h0017, 16'h0099, 16'h0128, 16'h0005};
        step();
        for (int c = 0; c < 40; c++) begin
            start0 = 1'b1;
            bin0   = (c % 10 == 0) ? vals[c / 10] : 8'(c * 13 + 200);
            step();
            checks++; if (done0 !== (c % 10 == 8)) begin failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c, done0, (c % 10 == 8)); end
            if (c % 10 == 8) begin
                checks++; if (bcd0 !== exp_bcd[c / 10]) begin failures++; $display("FAIL b2b_bcd_%0d got=%h exp=%h", c / 10, bcd0, exp_bcd[c / 10]); end
            end
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset_abort();
        int seen;
        step();
        start0 = 1'b1; bin0 = 8'd99;
        step();
        start0 = 1'b0;
        step(); step(); step();
        checks++; if (bcd0 !== 16'h0005) begin failures++; $display("FAIL abort_hold got=%h exp=0005", bcd0); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if ({busy0, done0, ovf0} !== 3'b000) begin failures++; $display("FAIL abort_ctrl got=%b exp=000", {busy0, done0, ovf0}); end
        checks++; if (bcd0 !== 16'h0000) begin failures++; $display("FAIL abort_bcd got=%h exp=0000", bcd0); end
        checks++; if (seg0 !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL abort_seg got=%h exp=%h", seg0, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done0) seen++;
        end
        checks++; if (seen != 0 || bcd0 !== 16'h0000) begin failures++; $display("FAIL abort_after got=%0d/%h exp=0/0000", seen, bcd0); end
    endtask

    task automatic test_wide();
        bit got;
        step();
        start2 = 1'b1; bin2 = 16'd65535;
        step();
        start2 = 1'b0; bin2 = 16'd7;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++; if (done2 !== (k == 16)) begin failures++; $display("FAIL wide_done_k%0d got=%b exp=%b", k, done2, (k == 16)); end
        end
        checks++; if ({ovf2, bcd2} !== {1'b0, 20'h65535}) begin failures++; $display("FAIL wide_bcd got=%h exp=%h", {ovf2, bcd2}, {1'b0, 20'h65535}); end
        checks++; if (seg2 !== {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}) begin failures++; $display("FAIL wide_seg got=%h exp=%h", seg2, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}); end
        step();
        start2 = 1'b1; bin2 = 16'd0;
        step();
        start2 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (done2) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL wide0_timeout got=0 exp=1"); end
        checks++; if (bcd2 !== 20'h00000) begin failures++; $display("FAIL wide0_bcd got=%h exp=00000", bcd2); end
        checks++; if (seg2 !== {5{7'h40}}) begin failures++; $display("FAIL wide0_seg got=%h exp=%h", seg2, {5{7'h40}}); end
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_convert();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
